// File: rtl/oc3_output_checker.sv
// Cross-checks three oc3 implementations after a settle window.
// Counts failed compares and post-settle output glitches.
module oc3_output_checker #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       abc,
  input  logic [1:0]       y_sl,
  input  logic [1:0]       y_gl,
  input  logic [1:0]       y_ass,
  input  logic             clear,
  output logic             settled,
  output logic             match,
  output logic [1:0]       ref_y,
  output logic             mismatch_pls,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SETTLE,
    CHECK,
    STABLE
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [2:0]       abc_m_q, abc_s_q, abc_q;
  logic [5:0]       y_m_q, y_s_q, y_q;
  logic             settled_q, settled_d;
  logic             match_q, match_d;
  logic [1:0]       ref_q, ref_d;
  logic             pls_q, pls_d;
  logic [CNT_W-1:0] mm_q, mm_d;
  logic [CNT_W-1:0] gl_q, gl_d;
  logic             mm_inc, gl_inc;
  logic             in_chg, y_chg, eq;

  // y bundle layout: {sl, gl, ass}
  assign in_chg = (abc_s_q != abc_q);
  assign y_chg  = (y_s_q != y_q);
  assign eq     = (y_s_q[5:4] == y_s_q[3:2]) &&
                  (y_s_q[3:2] == y_s_q[1:0]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    match_d   = match_q;
    ref_d     = ref_q;
    pls_d     = 1'b0;
    mm_inc    = 1'b0;
    gl_inc    = 1'b0;
    unique case (state_q)
      SETTLE: begin
        if (in_chg || y_chg) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (in_chg) begin
          state_d = SETTLE;
        end else begin
          match_d   = eq;
          ref_d     = y_s_q[5:4];
          settled_d = 1'b1;
          pls_d     = ~eq;
          mm_inc    = ~eq;
          state_d   = STABLE;
        end
      end
      STABLE: begin
        cnt_d = '0;
        if (in_chg) begin
          settled_d = 1'b0;
          state_d   = SETTLE;
        end else if (y_chg) begin
          gl_inc    = 1'b1;
          settled_d = 1'b0;
          state_d   = SETTLE;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // clear has priority over a same-cycle increment
  always_comb begin
    mm_d = mm_q;
    gl_d = gl_q;
    if (clear) begin
      mm_d = '0;
      gl_d = '0;
    end else begin
      if (mm_inc && (mm_q != CMAX)) mm_d = mm_q + 1'b1;
      if (gl_inc && (gl_q != CMAX)) gl_d = gl_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abc_m_q   <= '0;
      abc_s_q   <= '0;
      abc_q     <= '0;
      y_m_q     <= '0;
      y_s_q     <= '0;
      y_q       <= '0;
      state_q   <= SETTLE;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      match_q   <= 1'b0;
      ref_q     <= '0;
      pls_q     <= 1'b0;
      mm_q      <= '0;
      gl_q      <= '0;
    end else begin
      abc_m_q   <= abc;
      abc_s_q   <= abc_m_q;
      abc_q     <= abc_s_q;
      y_m_q     <= {y_sl, y_gl, y_ass};
      y_s_q     <= y_m_q;
      y_q       <= y_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      match_q   <= match_d;
      ref_q     <= ref_d;
      pls_q     <= pls_d;
      mm_q      <= mm_d;
      gl_q      <= gl_d;
    end
  end

  assign settled      = settled_q;
  assign match        = match_q;
  assign ref_y        = ref_q;
  assign mismatch_pls = pls_q;
  assign mismatch_cnt = mm_q;
  assign glitch_cnt   = gl_q;

endmodule
